// File: rtl/mem_pkg.sv
// Shared types, limits and helpers for banked_rr_memory.
package mem_pkg;

  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 2;
  localparam int MAX_NUM_CH     = 8;
  localparam int MAX_WIDTH      = 256;
  localparam int MAX_BE         = MAX_WIDTH / 8;
  localparam int MAX_ADDR_WIDTH = 32;

  // Sized for the largest legal configuration; users zero-extend into it.
  typedef struct packed {
    logic                      wr_rd;
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic [MAX_WIDTH-1:0]      wdata;
    logic [MAX_BE-1:0]         be;
  } req_t;

  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BE-1:0]    be
  );
    logic [MAX_WIDTH-1:0] res;
    for (int b = 0; b < MAX_BE; b++) begin
      res[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; pointer moves past the
// granted channel whenever advance is high.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(ptr) + i) % NUM_CH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/banked_rr_memory.sv
// Multi-channel single-port memory with round-robin access, byte enables,
// RD_LAT of 1 or 2 and range errors. Define MEM_PARITY_EN for byte parity.
module banked_rr_memory
  import mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH     = 2,
  parameter int BE_WIDTH   = WIDTH / 8,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH-1:0]            wr_rd_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CH*WIDTH-1:0]      wdata_i,
  input  logic [NUM_CH*BE_WIDTH-1:0]   be_i,
  output logic [NUM_CH-1:0]            ready_o,
  output logic [NUM_CH-1:0]            rvalid_o,
  output logic [NUM_CH*WIDTH-1:0]      rdata_o,
`ifdef MEM_PARITY_EN
  output logic [NUM_CH-1:0]            par_err_o,
`endif
  output logic [NUM_CH-1:0]            err_o
);

  localparam int IDX_W = idx_width(NUM_CH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || NUM_CH < 1 || NUM_CH > MAX_NUM_CH ||
      (WIDTH % 8) != 0 || WIDTH > MAX_WIDTH || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_cfg
    $error("banked_rr_memory: unsupported parameter set");
  end

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  accept;
  req_t                  sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  in_range;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      cur_word;
  logic [MAX_WIDTH-1:0]  merged;
  logic                  wr_en;
  logic                  wr_err;
  logic                  rd_now;
  logic [WIDTH-1:0]      rd_data;
  logic                  unused_bits;

  // Reset also blocks grants so nothing is accepted while rst_i is low.
  assign req    = valid_i & {NUM_CH{rst_i}};
  assign accept = |grant;
  assign ready_o = grant;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk       (clk_i),
    .rst_b     (rst_i),
    .req       (req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel.wr_rd = wr_rd_i[c];
        sel.addr  = MAX_ADDR_WIDTH'(addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]);
        sel.wdata = MAX_WIDTH'(wdata_i[c*WIDTH +: WIDTH]);
        sel.be    = MAX_BE'(be_i[c*BE_WIDTH +: BE_WIDTH]);
      end
    end
  end

  assign sel_addr    = sel.addr[ADDR_WIDTH-1:0];
  assign in_range    = ({1'b0, sel_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign cur_word    = mem[sel_addr];
  assign merged      = byte_merge(MAX_WIDTH'(cur_word), sel.wdata, sel.be);
  assign unused_bits = ^{sel, merged};

  assign wr_en   = accept && sel.wr_rd && in_range;
  assign wr_err  = accept && sel.wr_rd && !in_range;
  assign rd_now  = accept && !sel.wr_rd;
  assign rd_data = in_range ? cur_word : '0;

`ifdef MEM_PARITY_EN
  logic [BE_WIDTH-1:0] par_mem [DEPTH];
  logic [BE_WIDTH-1:0] wr_par;
  logic [BE_WIDTH-1:0] calc_par;
  logic [BE_WIDTH-1:0] stored_par;
  logic                perr_now;

  always_comb begin
    wr_par   = par_mem[sel_addr];
    calc_par = '0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (sel.be[b]) wr_par[b] = ^sel.wdata[b*8 +: 8];
      calc_par[b] = ^rd_data[b*8 +: 8];
    end
  end

  assign stored_par = in_range ? par_mem[sel_addr] : '0;
  assign perr_now   = |(calc_par ^ stored_par);
`endif

  // Array is deliberately not reset; committed writes survive a reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[sel_addr] <= merged[WIDTH-1:0];
`ifdef MEM_PARITY_EN
      par_mem[sel_addr] <= wr_par;
`endif
    end
  end

  logic             ret_valid;
  logic             ret_err;
  logic [IDX_W-1:0] ret_ch;
  logic [WIDTH-1:0] ret_data;
`ifdef MEM_PARITY_EN
  logic             ret_perr;
`endif

  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic             stg_valid;
    logic             stg_err;
    logic [IDX_W-1:0] stg_ch;
    logic [WIDTH-1:0] stg_data;
`ifdef MEM_PARITY_EN
    logic             stg_perr;
`endif

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        stg_valid <= 1'b0;
        stg_err   <= 1'b0;
        stg_ch    <= '0;
        stg_data  <= '0;
`ifdef MEM_PARITY_EN
        stg_perr  <= 1'b0;
`endif
      end else begin
        stg_valid <= rd_now;
        stg_err   <= !in_range;
        stg_ch    <= grant_idx;
        stg_data  <= rd_data;
`ifdef MEM_PARITY_EN
        stg_perr  <= perr_now;
`endif
      end
    end

    assign ret_valid = stg_valid;
    assign ret_err   = stg_err;
    assign ret_ch    = stg_ch;
    assign ret_data  = stg_data;
`ifdef MEM_PARITY_EN
    assign ret_perr  = stg_perr;
`endif
  end else begin : g_lat1
    assign ret_valid = rd_now;
    assign ret_err   = !in_range;
    assign ret_ch    = grant_idx;
    assign ret_data  = rd_data;
`ifdef MEM_PARITY_EN
    assign ret_perr  = perr_now;
`endif
  end

  // Write errors report one cycle after accept; read errors ride with rvalid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= '0;
    end else begin
      rvalid_o <= '0;
      err_o    <= '0;
      if (wr_err) err_o[grant_idx] <= 1'b1;
      if (ret_valid) begin
        rvalid_o[ret_ch]               <= 1'b1;
        rdata_o[ret_ch*WIDTH +: WIDTH] <= ret_data;
        if (ret_err) err_o[ret_ch] <= 1'b1;
      end
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      par_err_o <= '0;
    end else begin
      par_err_o <= '0;
      if (ret_valid && ret_perr) par_err_o[ret_ch] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_banked_rr_memory.sv
// Directed bench: two instances (RD_LAT 2 and 1, DEPTH 48) driven in lockstep.
module tb_banked_rr_memory;

  localparam int W   = 16;
  localparam int D   = 48;
  localparam int AW  = 6;
  localparam int NCH = 2;
  localparam int BEW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   valid, wr_rd;
  logic [NCH*AW-1:0]  addr;
  logic [NCH*W-1:0]   wdata;
  logic [NCH*BEW-1:0] be;
  logic [NCH-1:0]   ready_a, rvalid_a, err_a, ready_b, rvalid_b, err_b;
  logic [NCH*W-1:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banked_rr_memory #(.WIDTH(W), .DEPTH(D), .NUM_CH(NCH), .RD_LAT(2)) u_dut_lat2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ready_o(ready_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  banked_rr_memory #(.WIDTH(W), .DEPTH(D), .NUM_CH(NCH), .RD_LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ready_o(ready_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  typedef struct {
    int          ch;
    bit          wr;
    int          adr;
    logic [15:0] wd;
    logic [1:0]  bev;
    logic [15:0] exp_d;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int j);
    return 16'h8000 ^ 16'(j * 291);
  endfunction

  // One isolated request; checks the return window of both latencies.
  task automatic do_req(input string tag, input int ch, input bit wr, input int adr,
                        input logic [15:0] wd, input logic [1:0] bev,
                        input logic [15:0] exp_d, input bit exp_err);
    int waited;
    @(posedge clk); #1;
    valid[ch] = 1'b1;
    wr_rd[ch] = wr;
    addr[ch*AW +: AW] = AW'(adr);
    wdata[ch*W +: W]  = wd;
    be[ch*BEW +: BEW] = bev;
    waited = 0;
    @(negedge clk);
    while (!ready_a[ch] && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready"}, 32'(ready_a[ch]), 32'd1);
    check({tag, "_ready_eq"}, 32'(ready_b), 32'(ready_a));
    @(posedge clk); #1;
    valid[ch] = 1'b0;
    @(negedge clk);
    check({tag, "_l1_rvalid"}, 32'(rvalid_b[ch]), 32'(!wr));
    if (!wr) check({tag, "_l1_rdata"}, 32'(rdata_b[ch*W +: W]), 32'(exp_d));
    check({tag, "_l1_err"}, 32'(err_b[ch]), 32'(exp_err));
    check({tag, "_l2_early"}, 32'(rvalid_a[ch]), 32'd0);
    check({tag, "_l2_wr_err"}, 32'(err_a[ch]), 32'(wr && exp_err));
    @(negedge clk);
    check({tag, "_l2_rvalid"}, 32'(rvalid_a[ch]), 32'(!wr));
    if (!wr) check({tag, "_l2_rdata"}, 32'(rdata_a[ch*W +: W]), 32'(exp_d));
    check({tag, "_l2_err"}, 32'(err_a[ch]), 32'(!wr && exp_err));
    check({tag, "_l1_once"}, 32'(rvalid_b[ch]), 32'd0);
    check({tag, "_l1_err_once"}, 32'(err_b[ch]), 32'd0);
  endtask

  initial begin
    int i0, i1, k, cyc;
    logic [NCH-1:0] r;

    // ch, wr, addr, wdata, be, expected rdata, expected err
    vecs.push_back('{0, 1'b1,  5, 16'hA5A5, 2'b11, 16'h0000, 1'b0});
    vecs.push_back('{0, 1'b0,  5, 16'h0000, 2'b00, 16'hA5A5, 1'b0});
    vecs.push_back('{0, 1'b1,  3, 16'hFFFF, 2'b11, 16'h0000, 1'b0});
    vecs.push_back('{0, 1'b1,  3, 16'h1234, 2'b01, 16'h0000, 1'b0});
    vecs.push_back('{1, 1'b0,  3, 16'h0000, 2'b00, 16'hFF34, 1'b0});
    vecs.push_back('{1, 1'b1,  3, 16'hABCD, 2'b10, 16'h0000, 1'b0});
    vecs.push_back('{0, 1'b0,  3, 16'h0000, 2'b00, 16'hAB34, 1'b0});
    vecs.push_back('{1, 1'b1,  7, 16'h0BEE, 2'b11, 16'h0000, 1'b0});
    vecs.push_back('{1, 1'b1, 47, 16'hC0DE, 2'b11, 16'h0000, 1'b0});
    vecs.push_back('{0, 1'b0, 47, 16'h0000, 2'b00, 16'hC0DE, 1'b0});
    vecs.push_back('{1, 1'b0, 50, 16'h0000, 2'b00, 16'h0000, 1'b1});
    vecs.push_back('{0, 1'b1, 50, 16'hDEAD, 2'b11, 16'h0000, 1'b1});
    vecs.push_back('{0, 1'b1,  0, 16'h5555, 2'b11, 16'h0000, 1'b0});
    vecs.push_back('{1, 1'b1,  0, 16'h1111, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{1, 1'b0,  0, 16'h0000, 2'b00, 16'h5555, 1'b0});
    vecs.push_back('{0, 1'b0, 47, 16'h0000, 2'b00, 16'hC0DE, 1'b0});

    rst = 1'b0;
    valid = '1;
    wr_rd = '0;
    addr = '0;
    wdata = '0;
    be = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_ready_a", 32'(ready_a), 32'd0);
    check("reset_ready_b", 32'(ready_b), 32'd0);
    check("reset_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
    check("reset_rdata_a", rdata_a, 32'd0);
    check("reset_rdata_b", rdata_b, 32'd0);
    check("reset_err", 32'({err_a, err_b}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    valid = '0;

    foreach (vecs[i]) begin
      do_req($sformatf("vec%0d", i), vecs[i].ch, vecs[i].wr, vecs[i].adr, vecs[i].wd,
             vecs[i].bev, vecs[i].exp_d, vecs[i].exp_err);
    end

    // Reset one cycle after a read accept drops the RD_LAT=2 return.
    @(posedge clk); #1;
    valid[0] = 1'b1;
    wr_rd[0] = 1'b0;
    addr[0 +: AW] = AW'(7);
    @(negedge clk);
    check("rst_rd_ready", 32'(ready_a[0]), 32'd1);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    valid[1] = 1'b1;
    wr_rd[1] = 1'b0;
    addr[AW +: AW] = AW'(7);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_grant_a", 32'(ready_a), 32'd0);
    check("rst_no_grant_b", 32'(ready_b), 32'd0);
    check("rst_l1_rvalid", 32'(rvalid_b[0]), 32'd1);
    check("rst_l1_rdata", 32'(rdata_b[0 +: W]), 32'h0BEE);
    check("rst_l2_pending", 32'(rvalid_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    valid = '0;
    @(negedge clk);
    check("rst_l2_flushed", 32'(rvalid_a), 32'd0);
    check("rst_rdata_a_clr", rdata_a, 32'd0);
    check("rst_rdata_b_clr", rdata_b, 32'd0);
    check("rst_rvalid_b_clr", 32'(rvalid_b), 32'd0);
    check("rst_err_clr", 32'({err_a, err_b}), 32'd0);
    @(negedge clk);
    check("rst_l2_flushed_late", 32'(rvalid_a), 32'd0);

    // Contention after reset: pointer starts at channel 0 and alternates.
    @(posedge clk); #1;
    i0 = 0; i1 = 0; k = 0; cyc = 0;
    while ((i0 < 4 || i1 < 4) && cyc < 40) begin
      valid[0] = (i0 < 4);
      wr_rd[0] = 1'b1;
      addr[0 +: AW] = AW'(10 + i0);
      wdata[0 +: W] = 16'(16'h1000 + i0);
      be[0 +: BEW] = 2'b11;
      valid[1] = (i1 < 4);
      wr_rd[1] = 1'b1;
      addr[AW +: AW] = AW'(20 + i1);
      wdata[W +: W] = 16'(16'h2000 + i1);
      be[BEW +: BEW] = 2'b11;
      @(negedge clk);
      r = ready_a;
      check($sformatf("cont_grant%0d", k), 32'(r), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_ready_eq", 32'(ready_b), 32'(r));
      @(posedge clk); #1;
      if (r[0]) i0++;
      if (r[1]) i1++;
      if (r != '0) k++;
      cyc++;
    end
    valid = '0;
    check("cont_all_done", 32'(i0 == 4 && i1 == 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_req($sformatf("cont_rd_a%0d", i), 1, 1'b0, 10 + i, 16'h0, 2'b00, 16'(16'h1000 + i), 1'b0);
      do_req($sformatf("cont_rd_b%0d", i), 0, 1'b0, 20 + i, 16'h0, 2'b00, 16'(16'h2000 + i), 1'b0);
    end
    do_req("rst_persist", 0, 1'b0, 7, 16'h0, 2'b00, 16'h0BEE, 1'b0);

    // Full sweep on channel 1, with an out-of-range write in between.
    @(posedge clk); #1;
    for (int j = 0; j < D; j++) begin
      valid[1] = 1'b1;
      wr_rd[1] = 1'b1;
      addr[AW +: AW] = AW'(j);
      wdata[W +: W] = pat(j);
      be[BEW +: BEW] = 2'b11;
      @(negedge clk);
      check($sformatf("sweep_wr_ready%0d", j), 32'(ready_a[1]), 32'd1);
      check("sweep_wr_err", 32'({err_a[1], err_b[1]}), 32'd0);
      @(posedge clk); #1;
    end
    valid[1] = 1'b0;
    do_req("oor_wr", 0, 1'b1, 50, 16'hDEAD, 2'b11, 16'h0, 1'b1);

    @(posedge clk); #1;
    for (int j = 0; j < D + 2; j++) begin
      if (j < D) begin
        valid[1] = 1'b1;
        wr_rd[1] = 1'b0;
        addr[AW +: AW] = AW'(j);
      end else begin
        valid[1] = 1'b0;
      end
      @(negedge clk);
      if (j < D) check($sformatf("sweep_rd_ready%0d", j), 32'(ready_a[1]), 32'd1);
      if (j >= 1 && j <= D) begin
        check($sformatf("sweep_l1_rvalid%0d", j - 1), 32'(rvalid_b[1]), 32'd1);
        check($sformatf("sweep_l1_rdata%0d", j - 1), 32'(rdata_b[W +: W]), 32'(pat(j - 1)));
      end
      if (j == D + 1) check("sweep_l1_end", 32'(rvalid_b[1]), 32'd0);
      if (j >= 2) begin
        check($sformatf("sweep_l2_rvalid%0d", j - 2), 32'(rvalid_a[1]), 32'd1);
        check($sformatf("sweep_l2_rdata%0d", j - 2), 32'(rdata_a[W +: W]), 32'(pat(j - 2)));
      end else begin
        check("sweep_l2_start", 32'(rvalid_a[1]), 32'd0);
      end
      check("sweep_rd_err", 32'({err_a, err_b}), 32'd0);
      @(posedge clk); #1;
    end
    valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
